pspin_her_feedback: RTL and testbench
=====================================

PSPIN_HER_FEEDBACK -- requirements
Module: pspin_her_feedback

Interface
REQ-001 SHALL have parameter C_MSGID_WIDTH, default 10, PsPIN message ID width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, PsPIN L2 packet buffer address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 20, allocator length width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, feedback buffer entries; power of 2 and at least 2.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, in-flight HER counter width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port her_fire, input, 1, asserted for one cycle per HER accepted by PsPIN (her_valid && her_ready).
REQ-009 SHALL have ports feedback_valid (input, 1) and feedback_ready (output, 1), the PsPIN handler-completion handshake.
REQ-010 SHALL have ports feedback_her_addr (input, AXI_ADDR_WIDTH), feedback_her_size (input, AXI_ADDR_WIDTH) and feedback_msgid (input, C_MSGID_WIDTH), the completed HER's packet address, size and message ID.
REQ-011 SHALL have ports dealloc_valid (output, 1) and dealloc_ready (input, 1), the buffer-free handshake to the ingress allocator.
REQ-012 SHALL have ports dealloc_addr (output, AXI_ADDR_WIDTH), dealloc_len (output, LEN_WIDTH) and dealloc_msgid (output, C_MSGID_WIDTH).
REQ-013 SHALL have ports stat_inflight (output, CNT_WIDTH), stat_completed (output, 32), stat_underflow (output, 1), stat_overflow (output, 1) and stat_clear (input, 1), the control-register view.
REQ-014 SHALL have port idle (output, 1), meaning no HER is in flight and no free request is pending; it gates reprogramming of the execution contexts.

Function
REQ-015 SHALL assert feedback_ready exactly when the FIFO is not full, with no combinational dependence on dealloc_ready.
REQ-016 SHALL push {addr, size[LEN_WIDTH-1:0], msgid} on each cycle where feedback_valid && feedback_ready, truncating size to LEN_WIDTH bits.
REQ-017 SHALL present the oldest entry on dealloc_* with dealloc_valid = FIFO not empty, registered: an entry pushed in cycle N is visible no earlier than cycle N+1.
REQ-018 SHALL pop on dealloc_valid && dealloc_ready, hold dealloc_* stable while valid && !ready, and preserve order.
REQ-019 SHALL, on a simultaneous push and pop, leave the occupancy unchanged; when full, a pop in that cycle SHALL NOT enable a push in the same cycle.
REQ-020 SHALL use read and write pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; full is MSBs differing with the rest equal, and empty is the pointers equal.
REQ-021 SHALL update stat_inflight each cycle as +1 on her_fire and -1 on a feedback handshake; when both occur in one cycle it SHALL stay unchanged.
REQ-022 SHALL, on a decrement at 0, hold stat_inflight at 0 and set stat_underflow sticky.
REQ-023 SHALL, on an increment at 2^CNT_WIDTH-1, saturate stat_inflight and set stat_overflow sticky.
REQ-024 SHALL increment stat_completed by 1 per feedback handshake, wrapping modulo 2^32.
REQ-025 SHALL, on stat_clear, zero stat_completed and both sticky flags the next cycle; stat_inflight SHALL NOT be cleared.
REQ-026 SHALL give precedence to a same-cycle event over stat_clear: the event's effect is applied after the clear (counter = 1, or flag = 1).
REQ-027 SHALL drive idle = (stat_inflight == 0) && FIFO empty, combinationally from registered state.

Reset
REQ-028 SHALL, while rst is high, drive feedback_ready=0, dealloc_valid=0, idle=1, all stat_* = 0, both pointers = 0, and dealloc_addr/len/msgid = 0.
REQ-029 SHALL discard all buffered entries on a reset asserted mid-operation; the first handshake is possible in the first cycle after rst deasserts.

Structure
REQ-030 SHALL take the feedback and dealloc field-width constants from the shared pspin_pkg alongside the HER generator's, so the msgid and address widths match the HER path.
REQ-031 SHALL implement the buffer as sub-module pspin_fb_fifo (synchronous, registered output); counters and flags stay in the top module.

Verification
REQ-032 SHALL cover: 3 her_fire pulses, then feedback addr 0x1000/size 0x40/msgid 5 with dealloc_ready=1 -> dealloc 0x1000/0x40/5 one cycle later, then stat_inflight=2 and stat_completed=1.
REQ-033 SHALL cover: dealloc_ready=0 with 16 feedbacks -> feedback_ready=0 after the 16th; then dealloc_ready=1 -> 16 frees in order and one stall cycle before the next accept.
REQ-034 SHALL cover: her_fire and a feedback handshake in the same cycle with inflight=4 -> stays 4.
REQ-035 SHALL cover: feedback with inflight=0 -> stat_underflow=1 and inflight=0; stat_clear -> underflow=0 and completed=0 next cycle.
REQ-036 SHALL cover: rst asserted with 5 entries buffered -> dealloc_valid=0, idle=1 and all stats 0 next cycle.
REQ-037 SHALL cover: feedback_her_size=0x1_2345_678 with LEN_WIDTH=20 -> dealloc_len=0x45678.

Source files
------------

// File: rtl/pspin_pkg.sv
// Shared PsPIN field widths and helpers used by the HER generator and the feedback path.
package pspin_pkg;

    localparam int unsigned PSPIN_MSGID_WIDTH = 10;
    localparam int unsigned PSPIN_ADDR_WIDTH  = 32;
    localparam int unsigned PSPIN_LEN_WIDTH   = 20;
    localparam int unsigned PSPIN_FB_DEPTH    = 16;
    localparam int unsigned PSPIN_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Default-width view of one buffered free request.
    typedef struct packed {
        logic [PSPIN_ADDR_WIDTH-1:0]  addr;
        logic [PSPIN_LEN_WIDTH-1:0]   len;
        logic [PSPIN_MSGID_WIDTH-1:0] msgid;
    } fb_entry_t;

    // Coincident increment and decrement cancel out.
    function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
        cnt_op_e op;
        op = CNT_HOLD;
        if (inc && !dec) op = CNT_INC;
        if (dec && !inc) op = CNT_DEC;
        return op;
    endfunction

endpackage

// File: rtl/pspin_fb_fifo.sv
// Synchronous FIFO for completed-HER free requests; outputs depend only on registered state.
module pspin_fb_fifo #(
    parameter int DATA_WIDTH = 62,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Extra pointer MSB tells a full buffer apart from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign o_wr_ready = !w_full && !rst;
    assign o_rd_valid = !w_empty && !rst;
    assign o_empty    = w_empty;

    assign w_push = i_wr_valid && o_wr_ready;
    assign w_pop  = o_rd_valid && i_rd_ready;

    // Zero when nothing is presented so the free bus never shows stale entries.
    assign o_rd_data = o_rd_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/pspin_her_feedback.sv
// Handler-completion feedback: buffers buffer-free requests and tracks in-flight HER statistics.
module pspin_her_feedback
    import pspin_pkg::*;
#(
    parameter int C_MSGID_WIDTH  = PSPIN_MSGID_WIDTH,
    parameter int AXI_ADDR_WIDTH = PSPIN_ADDR_WIDTH,
    parameter int LEN_WIDTH      = PSPIN_LEN_WIDTH,
    parameter int FIFO_DEPTH     = PSPIN_FB_DEPTH,
    parameter int CNT_WIDTH      = PSPIN_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      her_fire,
    input  logic                      feedback_valid,
    output logic                      feedback_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] feedback_her_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] feedback_her_size,
    input  logic [C_MSGID_WIDTH-1:0]  feedback_msgid,
    output logic                      dealloc_valid,
    input  logic                      dealloc_ready,
    output logic [AXI_ADDR_WIDTH-1:0] dealloc_addr,
    output logic [LEN_WIDTH-1:0]      dealloc_len,
    output logic [C_MSGID_WIDTH-1:0]  dealloc_msgid,
    output logic [CNT_WIDTH-1:0]      stat_inflight,
    output logic [31:0]               stat_completed,
    output logic                      stat_underflow,
    output logic                      stat_overflow,
    input  logic                      stat_clear,
    output logic                      idle
);

    localparam int ENTRY_W = AXI_ADDR_WIDTH + LEN_WIDTH + C_MSGID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [ENTRY_W-1:0]   w_wr_data;
    logic [ENTRY_W-1:0]   w_rd_data;
    logic                 w_fifo_empty;
    logic                 w_fb_hs;
    cnt_op_e              w_op;
    logic                 w_ovf_evt;
    logic                 w_udf_evt;
    logic [CNT_WIDTH-1:0] w_inflight_next;

    logic [CNT_WIDTH-1:0] r_inflight;
    logic [31:0]          r_completed;
    logic                 r_underflow;
    logic                 r_overflow;

    assign w_wr_data = {feedback_her_addr, feedback_her_size[LEN_WIDTH-1:0], feedback_msgid};

    pspin_fb_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_valid (feedback_valid),
        .o_wr_ready (feedback_ready),
        .i_wr_data  (w_wr_data),
        .o_rd_valid (dealloc_valid),
        .i_rd_ready (dealloc_ready),
        .o_rd_data  (w_rd_data),
        .o_empty    (w_fifo_empty)
    );

    assign {dealloc_addr, dealloc_len, dealloc_msgid} = w_rd_data;

    assign w_fb_hs   = feedback_valid && feedback_ready;
    assign w_op      = cnt_op(her_fire, w_fb_hs);
    assign w_ovf_evt = (w_op == CNT_INC) && (r_inflight == CNT_MAX);
    assign w_udf_evt = (w_op == CNT_DEC) && (r_inflight == '0);

    // Saturating counter: out-of-range steps hold the value and raise a sticky flag instead.
    always_comb begin
        w_inflight_next = r_inflight;
        case (w_op)
            CNT_INC: if (!w_ovf_evt) w_inflight_next = r_inflight + CNT_ONE;
            CNT_DEC: if (!w_udf_evt) w_inflight_next = r_inflight - CNT_ONE;
            default: w_inflight_next = r_inflight;
        endcase
    end

    // A clear lands first, so an event in the same cycle survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight  <= '0;
            r_completed <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_inflight  <= w_inflight_next;
            r_completed <= (stat_clear ? 32'd0 : r_completed) + {31'd0, w_fb_hs};
            r_underflow <= (r_underflow && !stat_clear) || w_udf_evt;
            r_overflow  <= (r_overflow && !stat_clear) || w_ovf_evt;
        end
    end

    assign stat_inflight  = r_inflight;
    assign stat_completed = r_completed;
    assign stat_underflow = r_underflow;
    assign stat_overflow  = r_overflow;

    assign idle = rst || ((r_inflight == '0) && w_fifo_empty);

endmodule

// File: tb/tb_pspin_her_feedback.sv
// Randomized and directed bench for pspin_her_feedback against a queue-based reference model.
module tb_pspin_her_feedback;

    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        her_fire;
    logic        feedback_valid;
    logic        feedback_ready;
    logic [31:0] feedback_her_addr;
    logic [31:0] feedback_her_size;
    logic [9:0]  feedback_msgid;
    logic        dealloc_valid;
    logic        dealloc_ready;
    logic [31:0] dealloc_addr;
    logic [19:0] dealloc_len;
    logic [9:0]  dealloc_msgid;
    logic [CNT_W-1:0] stat_inflight;
    logic [31:0] stat_completed;
    logic        stat_underflow;
    logic        stat_overflow;
    logic        stat_clear;
    logic        idle;

    always #5 clk = ~clk;

    pspin_her_feedback #(
        .C_MSGID_WIDTH  (10),
        .AXI_ADDR_WIDTH (32),
        .LEN_WIDTH      (20),
        .FIFO_DEPTH     (DEPTH),
        .CNT_WIDTH      (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .her_fire          (her_fire),
        .feedback_valid    (feedback_valid),
        .feedback_ready    (feedback_ready),
        .feedback_her_addr (feedback_her_addr),
        .feedback_her_size (feedback_her_size),
        .feedback_msgid    (feedback_msgid),
        .dealloc_valid     (dealloc_valid),
        .dealloc_ready     (dealloc_ready),
        .dealloc_addr      (dealloc_addr),
        .dealloc_len       (dealloc_len),
        .dealloc_msgid     (dealloc_msgid),
        .stat_inflight     (stat_inflight),
        .stat_completed    (stat_completed),
        .stat_underflow    (stat_underflow),
        .stat_overflow     (stat_overflow),
        .stat_clear        (stat_clear),
        .idle              (idle)
    );

    typedef struct {
        logic [31:0] addr;
        logic [19:0] len;
        logic [9:0]  msgid;
    } ent_t;

    ent_t        q[$];
    int          m_inflight;
    int unsigned m_completed;
    bit          m_uf;
    bit          m_of;
    bit          m_rst;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        bit   have;
        ent_t head;
        have = !m_rst && (q.size() > 0);
        head = '{32'd0, 20'd0, 10'd0};
        if (have) head = q[0];
        chk("fb_ready",  feedback_ready, (!m_rst && q.size() < DEPTH));
        chk("dl_valid",  dealloc_valid, have);
        chk("dl_addr",   dealloc_addr, head.addr);
        chk("dl_len",    dealloc_len, head.len);
        chk("dl_msgid",  dealloc_msgid, head.msgid);
        chk("inflight",  stat_inflight, m_inflight);
        chk("completed", stat_completed, m_completed);
        chk("underflow", stat_underflow, m_uf);
        chk("overflow",  stat_overflow, m_of);
        chk("idle",      idle, (m_rst || (m_inflight == 0 && q.size() == 0)));
    endtask

    // Drive one cycle at a falling edge, advance the model, then check at the next falling edge.
    task automatic step(input bit her, input bit fbv, input logic [31:0] addr,
                        input logic [31:0] size, input logic [9:0] id,
                        input bit drdy, input bit clr, input bit r);
        bit   acc;
        bit   pop;
        ent_t e;
        her_fire          = her;
        feedback_valid    = fbv;
        feedback_her_addr = addr;
        feedback_her_size = size;
        feedback_msgid    = id;
        dealloc_ready     = drdy;
        stat_clear        = clr;
        rst               = r;
        acc = !r && fbv && (q.size() < DEPTH);
        pop = !r && drdy && (q.size() > 0);
        if (r) begin
            q.delete();
            m_inflight  = 0;
            m_completed = 0;
            m_uf        = 0;
            m_of        = 0;
        end else begin
            if (pop) begin
                e = q.pop_front();
                $display("free addr=%h len=%h msgid=%0d", e.addr, e.len, e.msgid);
            end
            if (acc) q.push_back('{addr, size[19:0], id});
            if (clr) begin
                m_completed = 0;
                m_uf        = 0;
                m_of        = 0;
            end
            if (acc) m_completed++;
            if (her && !acc) begin
                if (m_inflight == CNT_MX) m_of = 1;
                else m_inflight++;
            end else if (acc && !her) begin
                if (m_inflight == 0) m_uf = 1;
                else m_inflight--;
            end
        end
        m_rst = r;
        @(negedge clk);
        check_all();
    endtask

    task automatic nop(input bit drdy);
        step(0, 0, 32'd0, 32'd0, 10'd0, drdy, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 32'd0, 32'd0, 10'd0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; her_fire = 0; feedback_valid = 0; feedback_her_addr = 0;
        feedback_her_size = 0; feedback_msgid = 0; dealloc_ready = 0; stat_clear = 0;
        m_inflight = 0; m_completed = 0; m_uf = 0; m_of = 0; m_rst = 1;
        @(negedge clk);
        check_all();
        do_reset();

        // Three HERs, one completion, free appears next cycle
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h1000, 32'h40, 10'd5, 1, 0, 0);
        chk("s1_valid", dealloc_valid, 1);
        chk("s1_addr", dealloc_addr, 32'h1000);
        chk("s1_len", dealloc_len, 20'h40);
        chk("s1_msgid", dealloc_msgid, 10'd5);
        chk("s1_inflight", stat_inflight, 2);
        chk("s1_completed", stat_completed, 1);
        nop(1);

        // Fill while the allocator stalls, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 32'h2000 + 32'(i * 16), 32'(i + 1), 10'(i), 0, 0, 0);
        chk("s2_full", feedback_ready, 0);
        step(0, 1, 32'hdead0000, 32'h99, 10'd99, 1, 0, 0);
        chk("s2_reopen", feedback_ready, 1);
        for (int i = 0; i < DEPTH - 1; i++) nop(1);
        chk("s2_empty", dealloc_valid, 0);

        // Simultaneous fire and completion
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h3000, 32'h80, 10'd7, 1, 0, 0);
        chk("s3_inflight", stat_inflight, 4);
        nop(1);

        // Underflow, then clear; clear with a concurrent completion
        do_reset();
        step(0, 1, 32'h4000, 32'h10, 10'd1, 1, 0, 0);
        chk("s4_uf", stat_underflow, 1);
        chk("s4_inflight", stat_inflight, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("s4_uf_clr", stat_underflow, 0);
        chk("s4_cmp_clr", stat_completed, 0);
        step(0, 1, 32'h4100, 32'h10, 10'd2, 1, 1, 0);
        chk("s4_cmp_prec", stat_completed, 1);
        nop(1);

        // Overflow saturates; a clear with a concurrent overflow keeps the flag
        do_reset();
        for (int i = 0; i < CNT_MX + 1; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("s5_of", stat_overflow, 1);
        chk("s5_sat", stat_inflight, CNT_MX);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("s5_of_prec", stat_overflow, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("s5_of_clr", stat_overflow, 0);

        // Reset with buffered entries
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 32'h5000 + 32'(i), 32'h20, 10'(i), 0, 0, 0);
        do_reset();
        chk("s6_valid", dealloc_valid, 0);
        chk("s6_idle", idle, 1);
        chk("s6_cmp", stat_completed, 0);
        nop(0);

        // Size truncation
        step(0, 1, 32'h6000, 32'h12345678, 10'd3, 0, 0, 0);
        chk("s7_len", dealloc_len, 20'h45678);
        nop(1);

        // Randomized traffic with varying allocator back-pressure
        for (int i = 0; i < 3000; i++) begin
            int unsigned p_rdy;
            p_rdy = ((i / 200) % 2 == 1) ? 20 : 80;
            step($urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 45,
                 $urandom, $urandom, 10'($urandom_range(0, 1023)),
                 $urandom_range(0, 99) < p_rdy,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
